// File: rtl/alu_issue_ctrl_pkg.sv
// alu_issue_ctrl_pkg: widths, FSM states, ALU op codes, branch conditions and status flag bit indices
package alu_issue_ctrl_pkg;
  localparam int DATA_W = 16;
  localparam int REG_AW = 3;
  localparam int FLAG_W = 5;
  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WB} state_e;
  localparam logic [3:0] OP_MOV = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_ADC = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_SBC = 4'h4;
  localparam logic [3:0] OP_CMP = 4'h5;
  localparam logic [3:0] OP_AND = 4'h6;
  localparam logic [3:0] OP_OR  = 4'h7;
  localparam logic [3:0] OP_XOR = 4'h8;
  localparam logic [3:0] OP_RLC = 4'h9;
  localparam logic [3:0] OP_RRC = 4'hA;
  localparam logic [2:0] COND_AL = 3'd0;
  localparam logic [2:0] COND_Z  = 3'd1;
  localparam logic [2:0] COND_NZ = 3'd2;
  localparam logic [2:0] COND_C  = 3'd3;
  localparam logic [2:0] COND_NC = 3'd4;
  localparam logic [2:0] COND_N  = 3'd5;
  localparam logic [2:0] COND_NN = 3'd6;
  localparam logic [2:0] COND_V  = 3'd7;
  localparam int FLAG_NEG   = 0;
  localparam int FLAG_ZERO  = 1;
  localparam int FLAG_OVF   = 2;
  localparam int FLAG_CARRY = 3;
  localparam int FLAG_OLD   = 4;
  typedef struct packed {
    logic [3:0]        op;
    logic              single;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs;
    logic              imm_en;
    logic [DATA_W-1:0] imm;
  } cmd_t;
  function automatic logic writes_rf(input logic [3:0] op);
    return op != OP_CMP;
  endfunction
endpackage

// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: decode/RF/Alu bundle; branch signals exist only with ALU_ISSUE_BRANCH_EN
interface alu_issue_ctrl_if;
  import alu_issue_ctrl_pkg::*;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_op;
  logic              cmd_single;
  logic [REG_AW-1:0] cmd_rd;
  logic [REG_AW-1:0] cmd_rs;
  logic              cmd_imm_en;
  logic [DATA_W-1:0] cmd_imm;
  logic [REG_AW-1:0] rf_raddr1;
  logic [REG_AW-1:0] rf_raddr2;
  logic [DATA_W-1:0] rf_rdata1;
  logic [DATA_W-1:0] rf_rdata2;
  logic              alu_single;
  logic [3:0]        alu_operator;
  logic [DATA_W-1:0] alu_value1;
  logic [DATA_W-1:0] alu_value2;
  logic [DATA_W-1:0] alu_result;
  logic [FLAG_W-1:0] alu_flags;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [FLAG_W-1:0] status;
  logic              done;
`ifdef ALU_ISSUE_BRANCH_EN
  logic              cmd_br;
  logic [2:0]        cmd_cond;
  logic              branch_taken;
`endif
  modport master (
`ifdef ALU_ISSUE_BRANCH_EN
    input cmd_br, input cmd_cond, output branch_taken,
`endif
    input cmd_valid, cmd_op, cmd_single, cmd_rd, cmd_rs, cmd_imm_en, cmd_imm,
    input rf_rdata1, rf_rdata2, alu_result, alu_flags,
    output cmd_ready, rf_raddr1, rf_raddr2, alu_single, alu_operator, alu_value1, alu_value2,
    output rf_we, rf_waddr, rf_wdata, status, done
  );
  modport slave (
`ifdef ALU_ISSUE_BRANCH_EN
    output cmd_br, output cmd_cond, input branch_taken,
`endif
    output cmd_valid, cmd_op, cmd_single, cmd_rd, cmd_rs, cmd_imm_en, cmd_imm,
    output rf_rdata1, rf_rdata2, alu_result, alu_flags,
    input cmd_ready, rf_raddr1, rf_raddr2, alu_single, alu_operator, alu_value1, alu_value2,
    input rf_we, rf_waddr, rf_wdata, status, done
  );
endinterface

// File: rtl/alu_cond_eval.sv
// alu_cond_eval: branch condition against {carry, overflow, zero, negative}
module alu_cond_eval
  import alu_issue_ctrl_pkg::*;
(
  input  logic [3:0] flags_i,
  input  logic [2:0] cond_i,
  output logic       taken_o
);
  logic [7:0] t;
  assign t = {flags_i[FLAG_OVF], ~flags_i[FLAG_NEG], flags_i[FLAG_NEG], ~flags_i[FLAG_CARRY],
              flags_i[FLAG_CARRY], ~flags_i[FLAG_ZERO], flags_i[FLAG_ZERO], 1'b1};
  assign taken_o = t[cond_i];
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one ALU command per 3 cycles (IDLE/READ/WB), writes back, latches flags; ALU_ISSUE_BRANCH_EN adds branches
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
(
  input logic clk,
  input logic reset,
  alu_issue_ctrl_if.master bus
);
  state_e            state_q, state_d;
  cmd_t              cmd_q;
  logic [FLAG_W-1:0] status_q;
  logic              accept, rd_st, wb_st, br_in, is_br;
  assign rd_st  = state_q == ST_READ;
  assign wb_st  = state_q == ST_WB;
  assign accept = bus.cmd_valid & bus.cmd_ready;
`ifdef ALU_ISSUE_BRANCH_EN
  logic       br_q, taken;
  logic [2:0] cond_q;
  assign br_in = bus.cmd_br;
  assign is_br = br_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      br_q   <= 1'b0;
      cond_q <= '0;
    end else if (accept) begin
      br_q   <= bus.cmd_br;
      cond_q <= bus.cmd_cond;
    end
  alu_cond_eval u_cond (.flags_i(status_q[FLAG_CARRY:0]), .cond_i(cond_q), .taken_o(taken));
  assign bus.branch_taken = wb_st & br_q & taken;
`else
  assign br_in = 1'b0;
  assign is_br = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q  <= ST_IDLE;
      cmd_q    <= '0;
      status_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept)
        cmd_q <= '{op: bus.cmd_op, single: bus.cmd_single, rd: bus.cmd_rd, rs: bus.cmd_rs,
                   imm_en: bus.cmd_imm_en, imm: bus.cmd_imm};
      if (wb_st && !is_br)
        status_q <= bus.alu_flags;
    end
  // Outside READ the Alu sees MOV of zero so its internal carry survives idle cycles
  always_comb begin
    state_d          = rd_st ? ST_WB : wb_st ? ST_IDLE :
                       accept ? (br_in ? ST_WB : ST_READ) : ST_IDLE;
    bus.cmd_ready    = state_q == ST_IDLE && !reset;
    bus.rf_raddr1    = cmd_q.rd;
    bus.rf_raddr2    = cmd_q.rs;
    bus.alu_single   = rd_st & cmd_q.single;
    bus.alu_operator = rd_st ? cmd_q.op : OP_MOV;
    bus.alu_value1   = rd_st ? bus.rf_rdata1 : '0;
    bus.alu_value2   = !rd_st ? '0 : cmd_q.imm_en ? cmd_q.imm : bus.rf_rdata2;
    bus.rf_we        = wb_st && !is_br && writes_rf(cmd_q.op);
    bus.rf_waddr     = cmd_q.rd;
    bus.rf_wdata     = wb_st ? bus.alu_result : '0;
    bus.done         = wb_st;
  end
  assign bus.status = status_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: scoreboard bench with behavioural RF and Alu around alu_issue_ctrl
module tb_alu_issue_ctrl;
  import alu_issue_ctrl_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  alu_issue_ctrl_if bus ();
  alu_issue_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0, failures = 0, cyc = 0, last_acc = 0, we_cnt = 0;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, act, exp);
    end
  endtask
  always @(posedge clk) cyc <= cyc + 1;

  logic [DATA_W-1:0] rf [8];
  logic              pre_we = 1'b0;
  logic [2:0]        pre_addr = '0;
  logic [DATA_W-1:0] pre_data = '0;
  always @(posedge clk)
    if (pre_we) rf[pre_addr] <= pre_data;
    else if (bus.rf_we) rf[bus.rf_waddr] <= bus.rf_wdata;
  assign bus.rf_rdata1 = rf[bus.rf_raddr1];
  assign bus.rf_rdata2 = rf[bus.rf_raddr2];

  // Alu model: flags {old_sign, carry, overflow, zero, negative}, carry kept by non-arith ops
  logic alu_c = 1'b0;
  logic [20:0] alu_n;
  function automatic logic [20:0] alu_f(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input logic cin);
    logic [16:0] s;
    logic c, v;
    case (op)
      OP_ADD, OP_ADC: begin
        s = {1'b0, a} + {1'b0, b} + {16'd0, op == OP_ADC ? cin : 1'b0};
        c = s[16];
        v = (a[15] == b[15]) && (s[15] != a[15]);
      end
      OP_SUB, OP_CMP: begin
        s = {1'b0, a} - {1'b0, b};
        c = s[16];
        v = (a[15] != b[15]) && (s[15] != a[15]);
      end
      default: begin
        s = {1'b0, a};
        c = cin;
        v = 1'b0;
      end
    endcase
    return {a[15], c, v, s[15:0] == 16'd0, s[15], s[15:0]};
  endfunction
  assign alu_n = alu_f(bus.alu_operator, bus.alu_value1, bus.alu_value2, alu_c);
  always @(posedge clk) begin
    bus.alu_flags  <= alu_n[20:16];
    bus.alu_result <= alu_n[15:0];
    alu_c          <= alu_n[19];
  end

  typedef struct {
    logic        we;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic [4:0]  st;
    int          lat;
    logic        br;
    logic [2:0]  cond;
    logic        taken;
    int          acc;
  } exp_t;
  exp_t sb[$];
  exp_t m;
  logic       pend = 1'b0;
  logic [4:0] pend_st;
  always @(negedge clk) begin
    if (bus.rf_we) we_cnt++;
    if (pend) begin
      check("status", 32'(bus.status), 32'(pend_st));
      pend = 1'b0;
    end
    if (!reset && bus.done) begin
      if (sb.size() == 0) check("done_unexpected", 32'(bus.done), 32'd0);
      else begin
        m = sb.pop_front();
        check("latency", cyc - m.acc, m.lat);
        check("rf_we", 32'(bus.rf_we), 32'(m.we));
        if (m.we) check("rf_waddr", 32'(bus.rf_waddr), 32'(m.waddr));
        if (!m.br) check("rf_wdata", 32'(bus.rf_wdata), 32'(m.wdata));
`ifdef ALU_ISSUE_BRANCH_EN
        check("branch_taken", 32'(bus.branch_taken), 32'(m.taken));
`endif
        pend = 1'b1;
        pend_st = m.st;
      end
    end
  end

  task automatic preload(input logic [2:0] a, input logic [15:0] d);
    repeat (3) @(posedge clk);
    #1 pre_we = 1'b1;
    pre_addr = a;
    pre_data = d;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs, input logic imm_en,
                       input logic [15:0] imm, input logic br, input logic [2:0] cond, input logic we,
                       input logic [15:0] wdata, input logic [4:0] st, input logic taken);
    exp_t e;
    int n;
    bus.cmd_op = op;
    bus.cmd_single = 1'b0;
    bus.cmd_rd = rd;
    bus.cmd_rs = rs;
    bus.cmd_imm_en = imm_en;
    bus.cmd_imm = imm;
`ifdef ALU_ISSUE_BRANCH_EN
    bus.cmd_br = br;
    bus.cmd_cond = cond;
`endif
    bus.cmd_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.cmd_ready && n < 20);
    if (!bus.cmd_ready) begin
      check("accept_timeout", 32'(bus.cmd_ready), 32'd1);
      bus.cmd_valid = 1'b0;
      return;
    end
    e.we = we;
    e.waddr = rd;
    e.wdata = wdata;
    e.st = st;
    e.lat = br ? 1 : 2;
    e.br = br;
    e.cond = cond;
    e.taken = taken;
    e.acc = cyc;
    sb.push_back(e);
    last_acc = cyc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int a_acc, w0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = '0;
    bus.cmd_single = 1'b0;
    bus.cmd_rd = '0;
    bus.cmd_rs = '0;
    bus.cmd_imm_en = 1'b0;
    bus.cmd_imm = '0;
`ifdef ALU_ISSUE_BRANCH_EN
    bus.cmd_br = 1'b0;
    bus.cmd_cond = '0;
`endif
    #2;
    check("rst_ready", 32'(bus.cmd_ready), 32'd0);
    check("rst_we", 32'(bus.rf_we), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_status", 32'(bus.status), 32'd0);
    check("rst_op", 32'(bus.alu_operator), 32'(OP_MOV));
    check("rst_single", 32'(bus.alu_single), 32'd0);
    check("rst_vals", {bus.alu_value1, bus.alu_value2}, 32'd0);
    check("rst_raddr", 32'(bus.rf_raddr1), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1 check("ready_after_rst", 32'(bus.cmd_ready), 32'd1);

    preload(3'd1, 16'h0010);
    preload(3'd2, 16'h0005);
    issue(OP_ADD, 3'd1, 3'd2, 1'b0, 16'h0, 1'b0, 3'd0, 1'b1, 16'h0015, 5'h00, 1'b0);
    bus.cmd_valid = 1'b0;
    check("read_op", 32'(bus.alu_operator), 32'(OP_ADD));
    check("read_v1", 32'(bus.alu_value1), 32'h0010);
    check("read_v2", 32'(bus.alu_value2), 32'h0005);
    check("busy_ready", 32'(bus.cmd_ready), 32'd0);
    issue(OP_ADD, 3'd2, 3'd2, 1'b0, 16'h0, 1'b0, 3'd0, 1'b1, 16'h000A, 5'h00, 1'b0);
    bus.cmd_valid = 1'b0;
    preload(3'd1, 16'h0003);
    issue(OP_CMP, 3'd1, 3'd0, 1'b1, 16'h0003, 1'b0, 3'd0, 1'b0, 16'h0000, 5'h02, 1'b0);
    bus.cmd_valid = 1'b0;

    issue(OP_ADD, 3'd1, 3'd2, 1'b0, 16'h0, 1'b0, 3'd0, 1'b1, 16'h0, 5'h00, 1'b0);
    bus.cmd_valid = 1'b0;
    w0 = we_cnt;
    reset = 1'b1;
    sb.delete();
    #1;
    check("abort_ready", 32'(bus.cmd_ready), 32'd0);
    check("abort_status", 32'(bus.status), 32'd0);
    check("abort_op", 32'(bus.alu_operator), 32'(OP_MOV));
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    #1 check("abort_ready_after", 32'(bus.cmd_ready), 32'd1);
    repeat (4) @(negedge clk);
    check("abort_no_we", we_cnt - w0, 32'd0);

    preload(3'd3, 16'hFFFF);
    preload(3'd4, 16'h0000);
    issue(OP_ADD, 3'd3, 3'd0, 1'b1, 16'h0001, 1'b0, 3'd0, 1'b1, 16'h0000, 5'h1A, 1'b0);
    bus.cmd_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    issue(OP_ADC, 3'd4, 3'd0, 1'b1, 16'h0000, 1'b0, 3'd0, 1'b1, 16'h0001, 5'h00, 1'b0);
    bus.cmd_valid = 1'b0;

    preload(3'd5, 16'h1234);
    preload(3'd6, 16'h0001);
    preload(3'd7, 16'h8000);
    issue(OP_ADD, 3'd5, 3'd6, 1'b0, 16'h0, 1'b0, 3'd0, 1'b1, 16'h1235, 5'h00, 1'b0);
    a_acc = last_acc;
    issue(OP_ADD, 3'd7, 3'd0, 1'b1, 16'h8000, 1'b0, 3'd0, 1'b1, 16'h0000, 5'h1E, 1'b0);
    bus.cmd_valid = 1'b0;
    check("b2b_gap", last_acc - a_acc, 32'd3);

`ifdef ALU_ISSUE_BRANCH_EN
    w0 = we_cnt;
    issue(OP_ADD, 3'd1, 3'd2, 1'b0, 16'h0, 1'b1, COND_C, 1'b0, 16'h0, 5'h1E, 1'b1);
    issue(OP_ADD, 3'd1, 3'd2, 1'b0, 16'h0, 1'b1, COND_NC, 1'b0, 16'h0, 5'h1E, 1'b0);
    issue(OP_ADD, 3'd1, 3'd2, 1'b0, 16'h0, 1'b1, COND_Z, 1'b0, 16'h0, 5'h1E, 1'b1);
    bus.cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("br_no_we", we_cnt - w0, 32'd0);
`endif

    repeat (6) @(negedge clk);
    check("sb_drained", sb.size(), 32'd0);
    check("final_r4", 32'(rf[4]), 32'h0001);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
